// File: rtl/nano6502_io_pkg.sv
// Shared IO-page constants: bank numbers, IRQ register offsets, vector helper.
// Used by irq_controller (optional soft trigger: IRQ_SOFT_TRIG_EN).
package nano6502_io_pkg;

    localparam logic [7:0] IO_BANK_IRQ = 8'h07;

    localparam logic [2:0] IRQ_REG_PEND   = 3'd0;
    localparam logic [2:0] IRQ_REG_ENABLE = 3'd1;
    localparam logic [2:0] IRQ_REG_MODE   = 3'd2;
    localparam logic [2:0] IRQ_REG_VECTOR = 3'd3;
    localparam logic [2:0] IRQ_REG_CTRL   = 3'd4;
    localparam logic [2:0] IRQ_REG_RAW    = 3'd5;
    localparam logic [2:0] IRQ_REG_SOFT   = 3'd6;

    localparam logic [7:0] VECTOR_NONE = 8'h80;

    // Lowest set index wins; VECTOR_NONE when nothing is set.
    function automatic logic [7:0] irq_vector(input logic [7:0] act);
        logic [7:0] v;
        v = VECTOR_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) v = 8'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser chain followed by a previous-value flop.
// Produces the synchronised level and a one-cycle rise strobe.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// IO-page interrupt aggregator driving the CPU IRQ input.
// Define IRQ_SOFT_TRIG_EN to enable the write-1-to-set SOFT register.
module irq_controller
    import nano6502_io_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               R_W_n,
    input  logic [2:0]         reg_addr_i,
    input  logic [2:0]         reg_addr_r_i,
    input  logic [7:0]         data_i,
    input  logic               irq_cs,
    output logic [7:0]         data_o,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_o
);

    localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

    logic [7:0] w_level;
    logic [7:0] w_rise;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_soft;
    logic [7:0] w_active;
    logic [7:0] w_rdata;
    logic       w_wr;

    logic [7:0] r_pend;
    logic [7:0] r_enable;
    logic [7:0] r_mode;
    logic       r_ctrl;
    logic       r_irq;
    logic [7:0] r_data;

    for (genvar g = 0; g < 8; g++) begin : g_src
        if (g < NUM_SRC) begin : g_on
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .i_clk  (clk_i),
                .i_rst_n(rst_n_i),
                .i_src  (src_i[g]),
                .o_level(w_level[g]),
                .o_rise (w_rise[g])
            );
        end else begin : g_off
            assign w_level[g] = 1'b0;
            assign w_rise[g]  = 1'b0;
        end
    end

    assign w_wr = irq_cs & ~R_W_n;

    assign w_clr = (w_wr && reg_addr_i == IRQ_REG_PEND) ?
                   (data_i & SRC_MASK) : 8'h00;

`ifdef IRQ_SOFT_TRIG_EN
    assign w_soft = (w_wr && reg_addr_i == IRQ_REG_SOFT) ?
                    (data_i & SRC_MASK) : 8'h00;
`else
    assign w_soft = 8'h00;
`endif

    // Set sources are OR-ed after the clear so a colliding event is kept.
    assign w_set = (w_rise & r_mode) | (w_level & ~r_mode) | w_soft;
    assign w_active = r_pend & r_enable;

    always_comb begin
        w_rdata = 8'h00;
        case (reg_addr_r_i)
            IRQ_REG_PEND:   w_rdata = r_pend;
            IRQ_REG_ENABLE: w_rdata = r_enable;
            IRQ_REG_MODE:   w_rdata = r_mode;
            IRQ_REG_VECTOR: w_rdata = irq_vector(w_active);
            IRQ_REG_CTRL:   w_rdata = {7'b0, r_ctrl};
            IRQ_REG_RAW:    w_rdata = w_level;
            default:        w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend   <= 8'h00;
            r_enable <= 8'h00;
            r_mode   <= SRC_MASK;
            r_ctrl   <= 1'b0;
            r_irq    <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & SRC_MASK;
            r_irq  <= r_ctrl & |w_active;
            if (w_wr) begin
                case (reg_addr_i)
                    IRQ_REG_ENABLE: r_enable <= data_i & SRC_MASK;
                    IRQ_REG_MODE:   r_mode   <= data_i & SRC_MASK;
                    IRQ_REG_CTRL:   r_ctrl   <= data_i[0];
                    default:        ;
                endcase
            end
            if (irq_cs) begin
                r_data <= w_rdata;
            end
        end
    end

    assign data_o = r_data;
    assign irq_o  = r_irq;

endmodule
